// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-fetch pipeline stage.
package mips_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program-counter register: async active-low reset to RESET_PC, load-enabled update.
module pc_register
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH    = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, BOOT/RUN control and IF/ID register.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC   = DATA_WIDTH'(mips_pkg::RESET_PC),
    parameter logic [DATA_WIDTH-1:0]    NOP_WORD   = DATA_WIDTH'(mips_pkg::NOP_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic [25:0]           JumpTarget,
    input  logic                  JumpReg,
    input  logic [DATA_WIDTH-1:0] JumpRegAddr,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PCAddress,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
    output logic [DATA_WIDTH-1:0] IF_ID_PCPlus4,
    output logic                  IF_ID_Valid
);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jump_addr;
    logic [DATA_WIDTH-1:0] raw_target;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  redirect;
    logic                  pc_load;
    logic                  ifid_load;
    logic                  ifid_flush;

    // Addition is truncated to DATA_WIDTH, so 0xFFFF_FFFC + 4 wraps to zero.
    assign pc_plus4  = PCAddress + DATA_WIDTH'(PC_INCREMENT);
    assign jump_addr = {IF_ID_PCPlus4[DATA_WIDTH-1:28], JumpTarget, 2'b00};
    assign redirect  = JumpReg | Jump | BranchTaken;

    always_comb begin
        if (JumpReg) begin
            raw_target = JumpRegAddr;
        end else if (Jump) begin
            raw_target = jump_addr;
        end else begin
            raw_target = BranchTarget;
        end
    end

    pc_register #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (PCAddress)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        pc_next    = pc_plus4;
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            BOOT: begin
                // PC stays at RESET_PC; IF/ID is primed with a bubble while fetch begins.
                state_next = RUN;
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    pc_next    = {raw_target[DATA_WIDTH-1:2], 2'b00};
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                end else if (!Stall) begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (ifid_flush) begin
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (ifid_load) begin
            IF_ID_Instruction <= Instruction;
            IF_ID_PCPlus4     <= pc_plus4;
            IF_ID_Valid       <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage placed directly upstream of the program ROM. Holds the program counter, drives the word-aligned fetch address to the ROM, selects the next PC (sequential, branch, jump, jump-register) and registers the returned instruction into the IF/ID pipeline register. Supports stall from the hazard unit and bubble insertion on control-flow redirects.

## Interface
- DATA_WIDTH, 32, width of PC, addresses and instructions
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC and IF/ID contents (load-use hazard)
- BranchTaken  in  1  branch resolved taken in ID
- BranchTarget  in  DATA_WIDTH  branch target byte address
- Jump  in  1  j/jal decoded in ID
- JumpTarget  in  26  instr_index field of j/jal
- JumpReg  in  1  jr decoded in ID
- JumpRegAddr  in  DATA_WIDTH  register value for jr
- Instruction  in  DATA_WIDTH  combinational ROM output for PCAddress
- PCAddress  out  DATA_WIDTH  current PC, byte address, to ROM
- IF_ID_Instruction  out  DATA_WIDTH  registered instruction
- IF_ID_PCPlus4  out  DATA_WIDTH  registered PC+4 of that instruction
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Redirect = JumpReg | Jump | BranchTaken. Next-PC priority: JumpReg > Jump > BranchTaken > PC+4.
- Jump target = {IF_ID_PCPlus4[31:28], JumpTarget, 2'b00}. All targets have bits [1:0] forced to 2'b00.
- PC+4 wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC → 0x0000_0000); no carry out.
- Per rising edge, first matching case applies:
  - Redirect: PC ← selected target; IF/ID ← NOP_WORD, PCPlus4 0, Valid 0. Redirect overrides Stall.
  - Stall: PC, IF/ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid all hold.
  - Otherwise: PC ← PC+4; IF/ID ← {Instruction, PC+4, Valid 1}.
- Two-state control FSM: BOOT (after reset; first edge loads IF/ID with Valid 0 and PC ← RESET_PC+4 is NOT performed — PC stays RESET_PC, fetch begins) → RUN (unconditional next cycle). In RUN the rules above apply. Stall and Redirect are ignored in BOOT.

## Timing
- Reset (async, any time, including mid-stall or mid-redirect): PCAddress = RESET_PC, IF_ID_Instruction = NOP_WORD, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0, FSM = BOOT; takes effect immediately without a clock edge.
- PCAddress is a register output; ROM returns Instruction combinationally in the same cycle.
- Fetch latency: instruction at PC appears on IF_ID_Instruction one edge after PCAddress = PC.
- Redirect penalty: exactly one bubble; target instruction in IF/ID two edges after redirect asserted.
- Stall held N cycles → IF/ID and PC frozen N cycles; release resumes with no lost or duplicated instruction.
- Redirect and Stall in the same cycle → redirect taken, stall discarded for that cycle.

## Structure
- Shared package (mips_pkg): DATA_WIDTH, RESET_PC, NOP_WORD, PC_INCREMENT = 4.
- Sub-module pc_register: DATA_WIDTH register with async active-low reset to RESET_PC and load enable; instantiated for the PC. IF/ID register, next-PC mux and FSM in fetch_unit.

## Test plan
- Reset release, no stall, ROM word i = i: PCAddress 0,4,8,…; IF_ID_Instruction 0,1,2 one cycle later; first IF/ID Valid 0.
- Stall for 3 cycles at PC 0x0C: PCAddress stays 0x0C, IF_ID_Instruction stays word 2; after release word 3 then word 4, no duplicates.
- BranchTaken with BranchTarget 0x40 while PC = 0x10: next PCAddress 0x40, one Valid 0 bubble, then instruction at 0x40.
- Jump with JumpTarget 26'h10, IF_ID_PCPlus4 = 0x1000_0008 and simultaneous BranchTaken: PC ← 0x1000_0040 (jump wins); JumpReg with 0x23 simultaneously → PC ← 0x20 (jr wins, low bits cleared).
- PC = 0xFFFF_FFFC, no stall: next PCAddress 0x0000_0000, IF_ID_PCPlus4 0x0000_0000.
- Assert reset mid-stall and mid-redirect: outputs go to reset values before next edge; fetch restarts at RESET_PC via BOOT.
